// File: rtl/i2s_slave_tx.sv
// Philips I2S slave transmitter: bclk/lrclk come from an external master and are
// oversampled in the clk domain; stereo samples arrive through a one-deep holding register.
module i2s_slave_tx #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  audio_bclk,
  input  logic                  audio_lrclk,
  output logic                  audio_sdata,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_ldata,
  input  logic [DATA_WIDTH-1:0] in_rdata,
  output logic                  frame_start,
  output logic                  underrun
);

  localparam logic [CNT_WIDTH-1:0] CNT_SAT = CNT_WIDTH'(DATA_WIDTH);

  logic                  bclk_s1_q, bclk_s2_q, bclk_h_q;
  logic                  lr_s1_q, lr_s2_q;
  logic                  bclk_fall;
  logic                  accept;

  logic                  hold_empty_q, hold_empty_d;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
  logic [DATA_WIDTH-1:0] act_r_q, act_r_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  lr_seen_q, lr_seen_d;
  logic                  lr_prev_q, lr_prev_d;
  logic                  sdata_q, sdata_d;
  logic                  frame_start_q, frame_start_d;
  logic                  underrun_q, underrun_d;

  // Two-flop synchronisers plus a history stage on bclk for falling-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bclk_s1_q <= 1'b0;
      bclk_s2_q <= 1'b0;
      bclk_h_q  <= 1'b0;
      lr_s1_q   <= 1'b0;
      lr_s2_q   <= 1'b0;
    end else begin
      bclk_s1_q <= audio_bclk;
      bclk_s2_q <= bclk_s1_q;
      bclk_h_q  <= bclk_s2_q;
      lr_s1_q   <= audio_lrclk;
      lr_s2_q   <= lr_s1_q;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_empty_q  <= 1'b1;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      act_r_q       <= '0;
      shift_q       <= '0;
      cnt_q         <= '0;
      lr_seen_q     <= 1'b0;
      lr_prev_q     <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      hold_empty_q  <= hold_empty_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      act_r_q       <= act_r_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      lr_seen_q     <= lr_seen_d;
      lr_prev_q     <= lr_prev_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  // Next-state: channel starts, bit shifting and the holding-register handshake
  always_comb begin
    bclk_fall     = bclk_h_q & ~bclk_s2_q;
    accept        = in_valid & hold_empty_q;
    hold_empty_d  = hold_empty_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    act_r_d       = act_r_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    lr_seen_d     = lr_seen_q;
    lr_prev_d     = lr_prev_q;
    sdata_d       = sdata_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;

    if (bclk_fall) begin
      lr_prev_d = lr_s2_q;
      lr_seen_d = 1'b1;
      if (lr_seen_q && (lr_s2_q != lr_prev_q)) begin
        // Channel start: this bit period is the one-bit I2S delay slot
        sdata_d = 1'b0;
        cnt_d   = '0;
        if (!lr_s2_q) begin
          frame_start_d = 1'b1;
          if (!hold_empty_q) begin
            act_r_d      = hold_r_q;
            shift_d      = hold_l_q;
            hold_empty_d = 1'b1;
          end else begin
            act_r_d    = '0;
            shift_d    = '0;
            underrun_d = 1'b1;
          end
        end else begin
          shift_d = act_r_q;
        end
      end else if (cnt_q < CNT_SAT) begin
        sdata_d = shift_q[DATA_WIDTH-1];
        shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_WIDTH'(1);
      end else begin
        sdata_d = 1'b0;
      end
    end

    // An accept can only happen while empty, so it never collides with the hold->active move
    if (accept) begin
      hold_l_d     = in_ldata;
      hold_r_d     = in_rdata;
      hold_empty_d = 1'b0;
    end
  end

  assign audio_sdata = sdata_q;
  assign in_ready    = hold_empty_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule
